// File: rtl/piso_scan_reader_if.sv
// Bus between the scan reader, the external 8-bit PISO register and the byte consumer.
// The master modport is the reader; the slave modport is the PISO/consumer side.
interface piso_scan_reader_if;
    logic       start;
    logic       sr_qh;
    logic       sr_sh_ld_n;
    logic       sr_clk;
    logic       sr_clk_inh;
    logic [7:0] data;
    logic       data_valid;
    logic       data_ready;
    logic       busy;
    logic       dropped;

    modport master (
        input  start, sr_qh, data_ready,
        output sr_sh_ld_n, sr_clk, sr_clk_inh, data, data_valid, busy, dropped
    );

    modport slave (
        output start, sr_qh, data_ready,
        input  sr_sh_ld_n, sr_clk, sr_clk_inh, data, data_valid, busy, dropped
    );
endinterface

// File: rtl/piso_scan_reader.sv
// Reads one byte from an external 8-bit PISO shift register per start request.
// Every PISO control line and consumer flag comes straight from a register.
module piso_scan_reader #(
    parameter int unsigned CLK_DIV = 4
) (
    input logic                clk,
    input logic                rst,
    piso_scan_reader_if.master bus
);
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        CLK_HI,
        CLK_LO,
        DONE
    } state_t;

    localparam logic [7:0] H_RELOAD = 8'(CLK_DIV - 1);

    state_t     state;
    logic [7:0] hcnt;
    logic [7:0] sreg;
    logic [2:0] bit_cnt;
    logic       half_done;
    logic       accept;

    assign half_done = (hcnt == '0);
    assign accept    = (state == IDLE) && bus.start && (!bus.data_valid || bus.data_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            hcnt           <= '0;
            sreg           <= '0;
            bit_cnt        <= '0;
            bus.sr_sh_ld_n <= 1'b1;
            bus.sr_clk     <= 1'b0;
            bus.sr_clk_inh <= 1'b1;
            bus.data       <= '0;
            bus.data_valid <= 1'b0;
            bus.busy       <= 1'b0;
            bus.dropped    <= 1'b0;
        end else begin
            if (bus.data_valid && bus.data_ready)
                bus.data_valid <= 1'b0;
            if (bus.start && !accept)
                bus.dropped <= 1'b1;
            if (state != IDLE && !half_done)
                hcnt <= hcnt - 8'd1;

            case (state)
                IDLE: begin
                    if (accept) begin
                        state          <= LOAD;
                        hcnt           <= H_RELOAD;
                        bit_cnt        <= '0;
                        bus.sr_sh_ld_n <= 1'b0;
                        bus.busy       <= 1'b1;
                    end
                end
                LOAD: begin
                    if (half_done) begin
                        state          <= SETTLE;
                        hcnt           <= H_RELOAD;
                        bus.sr_sh_ld_n <= 1'b1;
                        bus.sr_clk_inh <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (half_done) begin
                        sreg       <= {bus.sr_qh, sreg[7:1]};
                        bit_cnt    <= '0;
                        state      <= CLK_HI;
                        hcnt       <= H_RELOAD;
                        bus.sr_clk <= 1'b1;
                    end
                end
                CLK_HI: begin
                    if (half_done) begin
                        state      <= CLK_LO;
                        hcnt       <= H_RELOAD;
                        bus.sr_clk <= 1'b0;
                    end
                end
                CLK_LO: begin
                    if (half_done) begin
                        sreg    <= {bus.sr_qh, sreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        hcnt    <= H_RELOAD;
                        // bit_cnt still holds the previous bit index, so 6 means bit 7 is being sampled
                        if (bit_cnt == 3'd6) begin
                            state          <= DONE;
                            bus.sr_clk_inh <= 1'b1;
                        end else begin
                            state      <= CLK_HI;
                            bus.sr_clk <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    bus.data       <= sreg;
                    bus.data_valid <= 1'b1;
                    state          <= IDLE;
                    hcnt           <= H_RELOAD;
                    bus.busy       <= 1'b0;
                end
                default: begin
                    state          <= IDLE;
                    hcnt           <= H_RELOAD;
                    bus.sr_sh_ld_n <= 1'b1;
                    bus.sr_clk     <= 1'b0;
                    bus.sr_clk_inh <= 1'b1;
                    bus.busy       <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_piso_scan_reader.sv
// Directed bench for piso_scan_reader: one instance at CLK_DIV=1, one at CLK_DIV=2,
// each fed by a behavioural PISO model; expected bytes and due cycles go through a queue.
module tb_piso_scan_reader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    piso_scan_reader_if b1 ();
    piso_scan_reader_if b2 ();

    piso_scan_reader #(.CLK_DIV(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    piso_scan_reader #(.CLK_DIV(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));

    // PISO models: parallel load while sh_ld_n low, shift right on each uninhibited sr_clk rise
    logic [7:0] pat1 = '0, pat2 = '0;
    logic [7:0] preg1 = '0, preg2 = '0;
    logic       pv1 = 1'b0, pv2 = 1'b0;

    always @(posedge clk) begin
        if (!b1.sr_sh_ld_n) preg1 <= pat1;
        else if (b1.sr_clk && !pv1 && !b1.sr_clk_inh) preg1 <= preg1 >> 1;
        pv1 <= b1.sr_clk;
        if (!b2.sr_sh_ld_n) preg2 <= pat2;
        else if (b2.sr_clk && !pv2 && !b2.sr_clk_inh) preg2 <= preg2 >> 1;
        pv2 <= b2.sr_clk;
    end
    assign b1.sr_qh = preg1[0];
    assign b2.sr_qh = preg2[0];

    // Edge counter and activity monitors
    int   cyc = 0;
    int   rise1 = 0, rise2 = 0, ld2 = 0, vr1 = 0, vr2 = 0;
    logic vp1 = 1'b0, vp2 = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (b1.sr_clk && !pv1) rise1 <= rise1 + 1;
        if (b2.sr_clk && !pv2) rise2 <= rise2 + 1;
        if (!b2.sr_sh_ld_n) ld2 <= ld2 + 1;
        if (b1.data_valid && !vp1) vr1 <= vr1 + 1;
        if (b2.data_valid && !vp2) vr2 <= vr2 + 1;
        vp1 <= b1.data_valid;
        vp2 <= b2.data_valid;
    end

    typedef struct {
        logic [7:0] val;
        int         due;
    } sb_t;
    sb_t sb[$];

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; leaves start high across exactly one posedge
    task automatic pulse_start(input int inst);
        if (inst == 1) b1.start = 1'b1;
        else           b2.start = 1'b1;
        @(negedge clk);
        b1.start = 1'b0;
        b2.start = 1'b0;
    endtask

    task automatic do_start(input int inst, input logic [7:0] pat);
        sb_t e;
        if (inst == 1) pat1 = pat;
        else           pat2 = pat;
        pulse_start(inst);
        e.val = pat;
        e.due = cyc + 16 * ((inst == 1) ? 1 : 2) + 1;
        sb.push_back(e);
    endtask

    task automatic wait_valid(input int inst, input string tag);
        int  n = 0;
        sb_t e;
        while (((inst == 1) ? b1.data_valid : b2.data_valid) !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, 32'(n < 200), 1);
        e = sb.pop_front();
        check({tag, "_data"}, (inst == 1) ? b1.data : b2.data, e.val);
        check({tag, "_latency"}, cyc, e.due);
    endtask

    int s_rise, s_rise1, s_ld, s_vr, n;

    initial begin
        b1.start = 1'b0; b2.start = 1'b0;
        b1.data_ready = 1'b1; b2.data_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ld_n", b2.sr_sh_ld_n, 1);
        check("rst_sr_clk", b2.sr_clk, 0);
        check("rst_inh", b2.sr_clk_inh, 1);
        check("rst_data", b2.data, 8'h00);
        check("rst_valid", b2.data_valid, 0);
        check("rst_busy", b2.busy, 0);
        check("rst_dropped", b2.dropped, 0);
        check("rst_valid_h1", b1.data_valid, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic scan at H=2
        s_rise = rise2; s_ld = ld2;
        do_start(2, 8'hA5);
        check("a5_busy", b2.busy, 1);
        wait_valid(2, "a5");
        check("a5_rises", rise2 - s_rise, 7);
        check("a5_load_cycles", ld2 - s_ld, 2);

        // Back-to-back at H=1; second start lands on the valid cycle with ready high
        s_rise1 = rise1;
        do_start(1, 8'h01);
        wait_valid(1, "b2b_01");
        do_start(1, 8'h80);
        wait_valid(1, "b2b_80");
        check("b2b_rises", rise1 - s_rise1, 14);
        check("b2b_dropped", b1.dropped, 0);
        @(negedge clk);
        check("b2b_valid_cleared", b1.data_valid, 0);

        // Consumer stalled: second start must be dropped and data held
        b2.data_ready = 1'b0;
        do_start(2, 8'h3C);
        wait_valid(2, "3c");
        s_rise = rise2;
        pat2 = 8'hFF;
        pulse_start(2);
        repeat (4) @(negedge clk);
        check("stall_dropped", b2.dropped, 1);
        check("stall_busy", b2.busy, 0);
        check("stall_data", b2.data, 8'h3C);
        check("stall_valid", b2.data_valid, 1);
        check("stall_no_shift", rise2 - s_rise, 0);
        b2.data_ready = 1'b1;
        @(negedge clk);
        check("stall_consumed", b2.data_valid, 0);
        check("stall_data_kept", b2.data, 8'h3C);

        // Reset clears sticky dropped
        rst = 1'b1;
        #1;
        check("rst_clears_dropped", b2.dropped, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Start while busy is ignored, scan continues unchanged
        s_rise = rise2; s_vr = vr2;
        do_start(2, 8'h5A);
        repeat (5) @(negedge clk);
        check("busy_pre", b2.busy, 1);
        pulse_start(2);
        check("busy_dropped", b2.dropped, 1);
        wait_valid(2, "busy_scan");
        repeat (40) @(negedge clk);
        check("busy_single_valid", vr2 - s_vr, 1);
        check("busy_rises", rise2 - s_rise, 7);
        check("busy_idle_after", b2.busy, 0);

        // Reset during CLK_HI of bit 4
        s_rise = rise2;
        pat2 = 8'hC3;
        pulse_start(2);
        n = 0;
        while (!(b2.sr_clk === 1'b1 && (rise2 - s_rise) == 4) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("bit4_reached", 32'(n < 200), 1);
        rst = 1'b1;
        #1;
        check("abort_sr_clk", b2.sr_clk, 0);
        check("abort_inh", b2.sr_clk_inh, 1);
        check("abort_ld_n", b2.sr_sh_ld_n, 1);
        check("abort_busy", b2.busy, 0);
        check("abort_valid", b2.data_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        s_vr = vr2;
        repeat (40) @(negedge clk);
        check("abort_no_partial", vr2 - s_vr, 0);
        s_rise = rise2;
        do_start(2, 8'h96);
        wait_valid(2, "post_abort");
        check("post_abort_rises", rise2 - s_rise, 7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
